// File: rtl/mmio_uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions and the transmitter state encoding.
package mmio_uart_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;

    // STATUS layout: {24'b0, count[3:0], ovf, empty, full, busy}
    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer; synchronous active-high reset.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_tx_fifo
    import mmio_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [7:0]              din,
    output logic [7:0]              dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: bus decode, registers, TX FIFO and serializer.
// Define UART_PARITY_EN to append an even-parity bit between the data bits and stop.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic [3:0]  byteEnable,
    output logic [31:0] ReadData,
    output logic        sel,
    output logic        tx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    off;
    logic          wr, push, pop, clr_ovf;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          busy, start_frame;
    logic [31:0]   status, rdata;

    uart_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_lat_q, div_lat_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;
`ifdef UART_PARITY_EN
    logic        par_q, par_d;
`endif

    logic unused_bits;
    assign unused_bits = ^{WriteData[31:16], DataAdr[1:0], byteEnable[3:2]};

    assign sel     = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign off     = DataAdr[3:2];
    assign wr      = MemWrite && sel;
    assign push    = wr && (off == OFF_TXDATA) && byteEnable[0];
    assign clr_ovf = wr && (off == OFF_STATUS) && byteEnable[0] && WriteData[ST_OVF];
    assign busy    = (state_q != IDLE);
    assign tx      = tx_q;

    // push/pop are single-cycle strobes: the FIFO takes din on push when it has
    // room (or is popped in the same cycle); pop is only raised while non-empty.
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (WriteData[7:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        div_d = div_q;
        if (wr && (off == OFF_BAUDDIV)) begin
            if (byteEnable[0]) div_d[7:0]  = WriteData[7:0];
            if (byteEnable[1]) div_d[15:8] = WriteData[15:8];
        end
        ovf_d = ovf_q;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
        else if (clr_ovf)              ovf_d = 1'b0;
    end

    always_comb begin
        status = '0;
        status[ST_BUSY]  = busy;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_OVF]   = ovf_q;
        status[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_count);
        case (off)
            OFF_STATUS:  rdata = status;
            OFF_BAUDDIV: rdata = {16'b0, div_q};
            default:     rdata = '0;
        endcase
    end

    assign ReadData = sel ? rdata : '0;

    // Every bit lasts div_lat_q+1 cycles: cnt_q counts down and reloads at each boundary.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_lat_d   = div_lat_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        pop         = 1'b0;
        start_frame = 1'b0;
`ifdef UART_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) start_frame = 1'b1;
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    state_d = DATA;
                    cnt_d   = div_lat_q;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = div_lat_q;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (cnt_q == 16'd0) begin
                    state_d = STOP;
                    cnt_d   = div_lat_q;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == 16'd0) begin
                    if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // Divisor is latched here so mid-frame BAUDDIV writes only affect the next frame.
        if (start_frame) begin
            pop       = 1'b1;
            state_d   = START;
            shift_d   = fifo_dout;
            div_lat_d = div_q;
            cnt_d     = div_q;
            tx_d      = 1'b0;
`ifdef UART_PARITY_EN
            par_d     = even_parity(fifo_dout);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_lat_q <= '0;
            div_q     <= DEFAULT_DIV;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
`ifdef UART_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_lat_q <= div_lat_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
`ifdef UART_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random bus traffic, with the
// serial line predicted cycle by cycle from a frame-level model of the transmitter.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE    = 32'hFFFF_0000;
    localparam int          DEPTH   = 4;
    localparam logic [15:0] DEF_DIV = 16'd433;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [3:0]  byteEnable = '0;
    logic [31:0] ReadData;
    logic        sel;
    logic        tx;

    mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .byteEnable (byteEnable),
        .ReadData   (ReadData),
        .sel        (sel),
        .tx         (tx)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    int total = 0;
    int bad   = 0;

    logic [7:0]    exp_q[$];      // bytes waiting in the transmitter queue
    int            rem = 0;       // cycles left in the frame on the line (0 = idle)
    int            dl  = 0;       // divisor used by the frame on the line
    logic [15:0]   mdiv = DEF_DIV;
    bit            movf = 1'b0;
    logic [NB-1:0] frame = '1;    // frame bits in send order, index 0 = start bit

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        logic [31:0] b;
        b = BASE;
        return a[31:4] == b[31:4];
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[7:4] = 4'(exp_q.size());
        s[3]   = movf;
        s[2]   = (exp_q.size() == 0);
        s[1]   = (exp_q.size() == DEPTH);
        s[0]   = (rem > 0);
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!in_win(a)) return '0;
        case (a[3:2])
            2'd1:    return model_status();
            2'd2:    return {16'b0, mdiv};
            default: return '0;
        endcase
    endfunction

    function automatic logic model_tx();
        int idx;
        if (rem == 0) return 1'b1;
        idx = (NB * (dl + 1) - rem) / (dl + 1);
        return frame[idx];
    endfunction

    // One clock edge of the spec's behaviour, using the inputs the DUT samples.
    task automatic model_edge();
        logic [7:0] b;
        bit pop;
        if (reset) begin
            exp_q.delete();
            rem  = 0;
            movf = 1'b0;
            mdiv = DEF_DIV;
            return;
        end
        pop = (rem <= 1) && (exp_q.size() > 0);
        if (pop) begin
            b = exp_q.pop_front();
            dl = int'(mdiv);
            frame = '1;
            frame[0] = 1'b0;
            for (int i = 0; i < 8; i++) frame[1 + i] = b[i];
`ifdef UART_PARITY_EN
            frame[9] = ^b;
`endif
            rem = NB * (dl + 1);
        end else if (rem > 0) begin
            rem--;
        end
        if (MemWrite && in_win(DataAdr)) begin
            case (DataAdr[3:2])
                2'd0: if (byteEnable[0]) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(WriteData[7:0]);
                    else movf = 1'b1;
                end
                2'd1: if (byteEnable[0] && WriteData[3]) movf = 1'b0;
                2'd2: begin
                    if (byteEnable[0]) mdiv[7:0]  = WriteData[7:0];
                    if (byteEnable[1]) mdiv[15:8] = WriteData[15:8];
                end
                default: ;
            endcase
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("tx", 32'(tx), 32'(model_tx()));
    endtask

    task automatic idle(input int n);
        MemWrite = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        MemWrite = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        MemWrite = 1'b1;
        DataAdr = a;
        WriteData = d;
        byteEnable = be;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] a);
        MemWrite = 1'b0;
        DataAdr = a;
        WriteData = '0;
        byteEnable = '0;
        #1;
        check({tag, "_sel"}, 32'(sel), 32'(in_win(a)));
        check(tag, ReadData, model_read(a));
    endtask

    // ---------------- stimulus ----------------
    logic [35:0] samp;
    logic [31:0] a;
    int r;

    initial begin
        // Reset state
        do_reset(2);
        do_read("rst_status", BASE + 32'h4);
        check("rst_status_k", ReadData, 32'h0000_0004);
        do_read("rst_div", BASE + 32'h8);
        check("rst_div_k", ReadData, 32'd433);

        // 1: single byte, div 3, latency and bit pattern
        do_write(BASE + 32'h8, 32'd3, 4'b0011);
        do_write(BASE + 32'h0, 32'hA5, 4'b0001);
        do_read("t1_cnt", BASE + 32'h4);
        check("t1_cnt_k", ReadData, 32'h0000_0010);
        check("t1_tx_hi", 32'(tx), 32'd1);
        tick();
        samp = {35'b0, tx};
        for (int i = 1; i < 36; i++) begin
            tick();
            samp = {samp[34:0], tx};
        end
        check("t1_bits", samp[31:0], 32'hF0F00F0F);
        check("t1_bits_hi", 32'(samp[35:32]), 32'h0);
        idle(4 * (NB - 9) + 4);
        do_read("t1_done", BASE + 32'h4);

        // 2: overflow with six back-to-back pushes
        for (int i = 1; i <= 6; i++) do_write(BASE, 32'(i), 4'b0001);
        do_read("t2_ovf", BASE + 32'h4);
        check("t2_ovf_k", 32'(ReadData[3]), 32'd1);
        idle(5 * 4 * NB + 8);
        do_write(BASE + 32'h4, 32'h8, 4'b0001);
        do_read("t2_clr", BASE + 32'h4);
        check("t2_clr_k", ReadData, 32'h0000_0004);

        // 3: partial BAUDDIV write and mid-frame divisor change
        do_write(BASE + 32'h8, 32'h1234, 4'b0001);
        do_read("t3_div", BASE + 32'h8);
        check("t3_div_k", ReadData, 32'h0000_0034);
        do_write(BASE, 32'h3C, 4'b0001);
        idle(20);
        do_write(BASE + 32'h8, 32'd7, 4'b1111);
        do_write(BASE, 32'h5A, 4'b0001);
        idle(NB * 53 + NB * 8 + 10);
        do_read("t3_end", BASE + 32'h4);

        // 4: reset in the middle of the data bits
        do_write(BASE + 32'h8, 32'd3, 4'b0011);
        do_write(BASE, 32'h81, 4'b0001);
        do_write(BASE, 32'h42, 4'b0001);
        idle(10);
        do_reset(1);
        check("t4_tx", 32'(tx), 32'd1);
        do_read("t4_status", BASE + 32'h4);
        check("t4_status_k", ReadData, 32'h0000_0004);
        idle(60);

        // 5: out-of-window loads/stores and the reserved register
        do_read("t5_out", (BASE + 32'h4) ^ 32'h0000_0100);
        check("t5_out_sel", 32'(sel), 32'd0);
        check("t5_out_rd", ReadData, 32'd0);
        do_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'b1111);
        do_write(BASE + 32'h10, 32'h55, 4'b1111);
        do_read("t5_status", BASE + 32'h4);
        check("t5_status_k", ReadData, 32'h0000_0004);
        do_read("t5_div", BASE + 32'h8);
        check("t5_div_k", ReadData, 32'd433);
        do_read("t5_rsv", BASE + 32'hC);
        idle(5);

        // 6: byte with odd weight (parity bit is 1 when enabled)
        do_write(BASE + 32'h8, 32'd1, 4'b0011);
        do_write(BASE, 32'h07, 4'b0001);
        idle(2 * NB + 4);

        // Random traffic
        do_write(BASE + 32'h8, 32'd2, 4'b0011);
        for (int n = 0; n < 1200; n++) begin
            r = $urandom_range(0, 99);
            if (r < 35) begin
                do_write(BASE, $urandom, 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 3) != 0));
            end else if (r < 45) begin
                do_write(BASE + 32'h8, 32'($urandom_range(0, 5)), 4'($urandom_range(0, 3)));
            end else if (r < 60) begin
                a = BASE + 32'(4 * $urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) a = a ^ (32'h10 << $urandom_range(0, 27));
                do_read("rnd_rd", a);
            end else if (r < 65) begin
                do_write(BASE + 32'h4, $urandom, 4'($urandom_range(0, 15)));
            end else if (r < 70) begin
                a = ($urandom_range(0, 1) == 0) ? BASE + 32'hC : BASE ^ (32'h10 << $urandom_range(0, 27));
                do_write(a, $urandom, 4'($urandom_range(0, 15)));
            end else if (r < 72) begin
                do_reset(1);
                do_write(BASE + 32'h8, 32'd2, 4'b0011);
            end else begin
                idle($urandom_range(1, 20));
            end
        end

        // Drain
        for (int i = 0; i < 20000 && (rem > 0 || exp_q.size() > 0); i++) tick();
        idle(3);
        do_read("final_status", BASE + 32'h4);
        check("final_idle", 32'(ReadData[2:0]), 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
